// File: rtl/mem_sweep_pkg.sv
// Shared types and pattern helper for the memory sweep checker.
package mem_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned PAT_W = 32;
  typedef logic [PAT_W-1:0] pat_word_t;

  // Address-derived test pattern: low wid bits of addr XOR seed.
  function automatic pat_word_t pat(input pat_word_t addr, input pat_word_t seed,
                                    input int unsigned wid);
    pat_word_t mask;
    mask = (wid >= PAT_W) ? '1 : ((pat_word_t'(1) << wid) - pat_word_t'(1));
    return (addr ^ seed) & mask;
  endfunction

endpackage

// File: rtl/mem_sweep_checker_if.sv
// Dual-port block-RAM port bundle between the sweep checker and the memory.
interface mem_sweep_checker_if #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned WID_MEM = 4
);
  logic [ADDR_W-1:0]  raddr;
  logic [ADDR_W-1:0]  waddr;
  logic [WID_MEM-1:0] din;
  logic [WID_MEM-1:0] mem_dout;

  modport master (output raddr, output waddr, output din, input mem_dout);
  modport slave  (input raddr, input waddr, input din, output mem_dout);
endinterface

// File: rtl/mem_sweep_cmp.sv
// Read-sweep comparator: delays expected data by one clock to meet registered
// dout, counts mismatches (saturating). First-error capture under MEMCHK_FIRST_ERR_EN.
module mem_sweep_cmp #(
  parameter int unsigned WID_MEM = 4,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned CNT_W   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               issue_vld,
  input  logic [ADDR_W-1:0]  issue_addr,
  input  logic [WID_MEM-1:0] issue_exp,
  input  logic [WID_MEM-1:0] mem_dout,
`ifdef MEMCHK_FIRST_ERR_EN
  output logic               first_err_vld,
  output logic [ADDR_W-1:0]  first_err_addr,
  output logic [WID_MEM-1:0] first_err_data,
`endif
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               vld_q, vld_d;
  logic [WID_MEM-1:0] exp_data_q, exp_data_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               mismatch_c;

`ifdef MEMCHK_FIRST_ERR_EN
  logic [ADDR_W-1:0]  exp_addr_q, exp_addr_d;
  logic               fe_vld_q, fe_vld_d;
  logic [ADDR_W-1:0]  fe_addr_q, fe_addr_d;
  logic [WID_MEM-1:0] fe_data_q, fe_data_d;
`endif

  assign mismatch_c = vld_q && (mem_dout != exp_data_q);

  always_comb begin
    vld_d      = issue_vld;
    exp_data_d = issue_exp;
    err_cnt_d  = err_cnt_q;
    if (mismatch_c && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
    if (clr) begin
      vld_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

`ifdef MEMCHK_FIRST_ERR_EN
  // Only the first mismatch of a run is latched; clr re-arms the capture.
  always_comb begin
    exp_addr_d = issue_addr;
    fe_vld_d   = fe_vld_q;
    fe_addr_d  = fe_addr_q;
    fe_data_d  = fe_data_q;
    if (mismatch_c && !fe_vld_q) begin
      fe_vld_d  = 1'b1;
      fe_addr_d = exp_addr_q;
      fe_data_d = mem_dout;
    end
    if (clr) begin
      fe_vld_d  = 1'b0;
      fe_addr_d = '0;
      fe_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_addr_q <= '0;
      fe_vld_q   <= 1'b0;
      fe_addr_q  <= '0;
      fe_data_q  <= '0;
    end else begin
      exp_addr_q <= exp_addr_d;
      fe_vld_q   <= fe_vld_d;
      fe_addr_q  <= fe_addr_d;
      fe_data_q  <= fe_data_d;
    end
  end

  assign first_err_vld  = fe_vld_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
`else
  logic unused_addr;
  assign unused_addr = ^issue_addr;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q      <= 1'b0;
      exp_data_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      exp_data_q <= exp_data_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: rtl/mem_sweep_checker.sv
// Memory test/scrub wrapper: passthrough mux, write/read sweep FSM and address counter.
// Optional first-error capture ports exist only when MEMCHK_FIRST_ERR_EN is defined.
module mem_sweep_checker
  import mem_sweep_pkg::*;
#(
  parameter int unsigned WID_MEM   = 4,
  parameter int unsigned DEPTH_MEM = 16384,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned CNT_W     = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                write_en,
  input  logic [WID_MEM-1:0]  seed,
  input  logic [ADDR_W-1:0]   user_raddr,
  input  logic [ADDR_W-1:0]   user_waddr,
  input  logic [WID_MEM-1:0]  user_din,
  mem_sweep_checker_if.master mem,
  output logic                busy,
  output logic                done,
`ifdef MEMCHK_FIRST_ERR_EN
  output logic                first_err_vld,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [WID_MEM-1:0]  first_err_data,
`endif
  output logic [CNT_W-1:0]    err_cnt
);

  // One spare bit so the terminal compare never aliases on a full-range depth.
  localparam int unsigned          CNT_A_W   = ADDR_W + 1;
  localparam logic [CNT_A_W-1:0]   LAST_ADDR = CNT_A_W'(DEPTH_MEM - 1);

  state_t               state_q, state_d;
  logic [CNT_A_W-1:0]   addr_q, addr_d;
  logic [WID_MEM-1:0]   seed_q, seed_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 run_clr;
  logic                 sweep_act;
  logic                 read_act;
  logic [WID_MEM-1:0]   sweep_pat;

  assign sweep_pat = WID_MEM'(pat(pat_word_t'(addr_q), pat_word_t'(seed_q), WID_MEM));
  assign sweep_act = (state_q == WRITE) || (state_q == READ);
  assign read_act  = (state_q == READ);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    run_clr = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          run_clr = 1'b1;
          seed_d  = seed;
          addr_d  = '0;
          state_d = write_en ? WRITE : READ;
        end
      end
      WRITE: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = READ;
        end else begin
          addr_d = addr_q + CNT_A_W'(1);
        end
      end
      READ: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + CNT_A_W'(1);
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // During sweeps the memory rewrites the pattern at the read address; the
  // memory is read-first, so the compared word is the pre-write content.
  always_comb begin
    mem.raddr = user_raddr;
    mem.waddr = user_waddr;
    mem.din   = user_din;
    if (sweep_act) begin
      mem.raddr = addr_q[ADDR_W-1:0];
      mem.waddr = addr_q[ADDR_W-1:0];
      mem.din   = sweep_pat;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  mem_sweep_cmp #(
    .WID_MEM (WID_MEM),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) u_cmp (
    .clk            (clk),
    .reset          (reset),
    .clr            (run_clr),
    .issue_vld      (read_act),
    .issue_addr     (addr_q[ADDR_W-1:0]),
    .issue_exp      (sweep_pat),
    .mem_dout       (mem.mem_dout),
`ifdef MEMCHK_FIRST_ERR_EN
    .first_err_vld  (first_err_vld),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
`endif
    .err_cnt        (err_cnt)
  );

endmodule
